// File: rtl/breakout_brick_state.sv
// Brick field state for a Breakout game: alive mask, score, ball hit-test FSM
// and a registered per-pixel brick lookup for the video path.
module breakout_brick_state #(
  parameter int block_width   = 40,
  parameter int block_height  = 20,
  parameter int block_spacing = 5,
  parameter int start_x       = 50,
  parameter int start_y       = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        level_reset,
  input  logic        check_req,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic        busy,
  output logic        check_ack,
  output logic        hit,
  output logic [1:0]  hit_row,
  output logic [3:0]  hit_col,
  output logic [39:0] alive_mask,
  output logic [5:0]  bricks_left,
  output logic        all_cleared,
  output logic [15:0] score,
  output logic        pixel_brick_on,
  output logic [1:0]  pixel_row
);

  localparam int num_cols   = 10;
  localparam int num_rows   = 4;
  localparam int pitch_x    = block_width + block_spacing;
  localparam int pitch_y    = block_height + block_spacing;
  localparam logic [5:0]  full_count = 6'd40;
  localparam logic [39:0] full_mask  = 40'hFF_FFFF_FFFF;

  typedef enum logic [1:0] {IDLE, LOCATE, UPDATE, DONE} state_t;

  typedef struct packed {
    logic       in_brick;
    logic [1:0] row;
    logic [3:0] col;
  } loc_t;

  // Range compares against each column/row window; nothing is subtracted,
  // so points left of or above the grid can never wrap into it.
  function automatic loc_t locate(input logic [9:0] x, input logic [9:0] y);
    loc_t loc;
    logic in_x;
    logic in_y;
    int   xi;
    int   yi;
    loc  = '0;
    in_x = 1'b0;
    in_y = 1'b0;
    xi   = int'(x);
    yi   = int'(y);
    for (int c = 0; c < num_cols; c++) begin
      if (xi >= start_x + c * pitch_x && xi < start_x + c * pitch_x + block_width) begin
        in_x    = 1'b1;
        loc.col = 4'(c);
      end
    end
    for (int r = 0; r < num_rows; r++) begin
      if (yi >= start_y + r * pitch_y && yi < start_y + r * pitch_y + block_height) begin
        in_y    = 1'b1;
        loc.row = 2'(r);
      end
    end
    loc.in_brick = in_x & in_y;
    if (!loc.in_brick) begin
      loc.row = 2'd0;
      loc.col = 4'd0;
    end
    return loc;
  endfunction

  function automatic logic [5:0] brick_index(input logic [1:0] row, input logic [3:0] col);
    return 6'({4'd0, row}) * 6'd10 + 6'({2'd0, col});
  endfunction

  function automatic logic [3:0] row_points(input logic [1:0] row);
    logic [3:0] pts;
    case (row)
      2'd0:    pts = 4'd7;
      2'd1:    pts = 4'd5;
      2'd2:    pts = 4'd3;
      default: pts = 4'd1;
    endcase
    return pts;
  endfunction

  state_t      state;
  state_t      state_next;
  logic [9:0]  test_x;
  logic [9:0]  test_y;
  loc_t        test_loc;
  logic [5:0]  test_idx;
  logic        hit_now;
  logic        accept;
  logic [16:0] score_sum;
  loc_t        pix_loc;
  logic        pix_on_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    check_ack  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (check_req && !level_reset) begin
          state_next = LOCATE;
          accept     = 1'b1;
        end
      end
      LOCATE: begin
        busy       = 1'b1;
        state_next = UPDATE;
      end
      UPDATE: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        check_ack  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (level_reset) begin
      state_next = IDLE;
    end
  end

  assign test_idx  = brick_index(test_loc.row, test_loc.col);
  assign hit_now   = test_loc.in_brick & alive_mask[test_idx];
  assign score_sum = {1'b0, score} + {13'd0, row_points(test_loc.row)};

  // A level restart wins over a hit resolving in the same cycle; the score
  // is never touched by it.
  always_ff @(posedge clk) begin
    if (reset) begin
      test_x      <= '0;
      test_y      <= '0;
      test_loc    <= '0;
      hit         <= 1'b0;
      hit_row     <= '0;
      hit_col     <= '0;
      alive_mask  <= full_mask;
      bricks_left <= full_count;
      score       <= '0;
    end else begin
      if (accept) begin
        test_x <= ball_x;
        test_y <= ball_y;
      end
      if (state == LOCATE) begin
        test_loc <= locate(test_x, test_y);
      end
      if (level_reset) begin
        alive_mask  <= full_mask;
        bricks_left <= full_count;
      end else if (state == UPDATE) begin
        hit <= hit_now;
        if (hit_now) begin
          alive_mask[test_idx] <= 1'b0;
          bricks_left          <= bricks_left - 6'd1;
          score                <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          hit_row              <= test_loc.row;
          hit_col              <= test_loc.col;
        end
      end
    end
  end

  assign all_cleared = (bricks_left == 6'd0);

  assign pix_loc     = locate(hCount, vCount);
  assign pix_on_next = pix_loc.in_brick & alive_mask[brick_index(pix_loc.row, pix_loc.col)];

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_brick_on <= 1'b0;
      pixel_row      <= '0;
    end else begin
      pixel_brick_on <= pix_on_next;
      pixel_row      <= pix_on_next ? pix_loc.row : 2'd0;
    end
  end

endmodule

// File: doc/breakout_brick_state.md
BREAKOUT_BRICK_STATE -- requirements
Module: breakout_brick_state

Interface
REQ-001 Parameters (name, default, meaning):
- block_width, 40, brick width in pixels.
- block_height, 20, brick height in pixels.
- block_spacing, 5, gap between bricks.
- start_x, 50, left edge of grid.
- start_y, 30, top edge of grid.
- Grid size is fixed at 10 columns x 4 rows.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on posedge.
- reset, in, 1, synchronous, active-high.
- level_reset, in, 1, restores all bricks; score is kept.
- check_req, in, 1, ball hit-test request.
- ball_x, in, 10, ball test point x.
- ball_y, in, 10, ball test point y.
- hCount, in, 10, current pixel column.
- vCount, in, 10, current pixel row.
- busy, out, 1, a hit test is in progress.
- check_ack, out, 1, one-cycle hit-test completion pulse.
- hit, out, 1, test point struck a live brick; valid while check_ack is high.
- hit_row, out, 2, row of the struck brick; valid with hit.
- hit_col, out, 4, column of the struck brick; valid with hit.
- alive_mask, out, 40, bit row*10+col = brick present.
- bricks_left, out, 6, count of live bricks.
- all_cleared, out, 1, high when bricks_left == 0.
- score, out, 16, accumulated points.
- pixel_brick_on, out, 1, pixel is on a live brick.
- pixel_row, out, 2, row of the brick under the pixel.

Function
REQ-003 Geometry: pitch_x = 45, pitch_y = 25; grid spans x 50..494 and y 30..124; the gap region is (x-50)%45 >= 40 or (y-30)%25 >= 20.
REQ-004 Compare first: test x < start_x or y < start_y before subtracting; no unsigned wrap may produce an in-grid result.
REQ-005 FSM states are IDLE, LOCATE, UPDATE, DONE; the reset state is IDLE.
REQ-006 IDLE: when check_req = 1, latch ball_x/ball_y, go to LOCATE, and set busy = 1 on the next cycle.
REQ-007 LOCATE: register in_brick, row and col from the latched point; go to UPDATE.
REQ-008 UPDATE: hit = in_brick AND alive_mask[row*10+col]. On hit: clear that bit, decrement bricks_left by 1, add points to score, latch hit_row/hit_col. Go to DONE.
REQ-009 Points per row: row0 = 7, row1 = 5, row2 = 3, row3 = 1. Score saturates at 16'hFFFF.
REQ-010 DONE: check_ack = 1 for exactly one cycle, busy = 0 in the same cycle, return to IDLE.
REQ-011 Latency: check_ack is high exactly 3 cycles after the check_req acceptance edge.
REQ-012 check_req is ignored while busy or in DONE; there is no queuing.
REQ-013 The next request is accepted no earlier than the cycle after DONE.
REQ-014 A miss (gap, outside grid, or dead brick) changes no state; hit = 0, and hit_row/hit_col hold their previous values.
REQ-015 level_reset in any state:
- alive_mask = all ones, bricks_left = 40 on the next edge.
- FSM returns to IDLE with no check_ack.
- score is unchanged.
REQ-016 level_reset coinciding with UPDATE takes priority: no decrement and no score added.
REQ-017 all_cleared is combinational from bricks_left == 0.
REQ-018 bricks_left never underflows, because a cleared bit is never re-cleared.
REQ-019 Pixel path, one-cycle registered: pixel_brick_on = in-brick(hCount, vCount) AND the alive bit; pixel_row is the row of that brick, else 0.
REQ-020 The pixel path runs every cycle, independent of the FSM.
REQ-021 A brick cleared in UPDATE is reflected in pixel_brick_on from the next cycle onward.

Reset
REQ-022 On reset:
- State = IDLE.
- busy = 0, check_ack = 0, hit = 0.
- hit_row = 0, hit_col = 0.
- alive_mask = 40'hFF_FFFF_FFFF.
- bricks_left = 40, all_cleared = 0.
- score = 0.
- pixel_brick_on = 0, pixel_row = 0.
REQ-023 Reset overrides level_reset and any in-flight test; no check_ack is issued for an aborted test.

Verification
REQ-024 Single hit: check_req with (70,40) -> check_ack 3 cycles later; hit = 1, row 0, col 0; alive_mask bit0 = 0; bricks_left = 39; score = 7.
REQ-025 Repeat and gap: same point again -> hit = 0, score stays 7. Point (92,40) in the x gap -> hit = 0. Point (40,40) -> hit = 0 with no wrap.
REQ-026 Busy: check_req held high for 6 cycles -> exactly two acks, at cycles 3 and 7 after the first acceptance.
REQ-027 Clear all: hit all 40 bricks -> score = 160, bricks_left = 0, all_cleared = 1. Then level_reset -> bricks_left = 40, score = 160.
REQ-028 Pixel: hCount/vCount = (60,35) -> pixel_brick_on = 1, pixel_row = 0 one cycle later. After brick 0 is cleared -> 0. (60,130) -> 0.
REQ-029 Mid-op: reset asserted in LOCATE, and separately level_reset asserted in UPDATE on a live brick -> no check_ack, no score change, bricks_left = 40.
